// File: rtl/emu_pkg.sv
// Shared types and constants for the co-emulation step transactor.
// Status byte layout and clock-step FSM encoding live here.
package emu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StCap
    } step_state_e;

    localparam int unsigned STATUS_BUSY_BIT = 7;
    localparam int unsigned STATUS_DONE_BIT = 6;

    localparam int unsigned DEFAULT_ADDR_W = 3;
    localparam int unsigned STATUS_ADDR    = (1 << DEFAULT_ADDR_W) - 1;

    // Status lives at the top of the host address space.
    function automatic int unsigned status_addr(input int unsigned addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic int unsigned phase_width(input int unsigned half_per);
        return (half_per > 1) ? $clog2(half_per) : 1;
    endfunction

endpackage

// File: rtl/emu_clk_stepper.sv
// DUT clock burst engine: emits N clk_dut periods of 2*HALF_PER clk_emu cycles,
// then optionally requests one capture cycle before dropping busy.
module emu_clk_stepper
    import emu_pkg::*;
#(
    parameter int unsigned HALF_PER = 1,
    parameter bit          AUTO_GET = 1'b1
) (
    input  logic       clk_emu,
    input  logic       nrst_emu,
    input  logic       start,
    input  logic [7:0] count,
    input  logic       clr_done,
    output logic       clk_dut,
    output logic       busy,
    output logic       done,
    output logic       cap_pulse
);

    localparam int unsigned           PhaseW    = phase_width(HALF_PER);
    localparam logic [PhaseW-1:0]     PhaseInit = PhaseW'(HALF_PER - 1);

    step_state_e       state_q;
    logic [7:0]        remaining_q;
    logic [PhaseW-1:0] phase_q;

    assign cap_pulse = (state_q == StCap);

    always_ff @(posedge clk_emu or negedge nrst_emu) begin
        if (!nrst_emu) begin
            state_q     <= StIdle;
            remaining_q <= 8'd0;
            phase_q     <= '0;
            clk_dut     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (clr_done) begin
                done <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (count == 8'd0) begin
                            // Zero-length burst only reports completion.
                            done <= 1'b1;
                        end else begin
                            state_q     <= StHigh;
                            clk_dut     <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            remaining_q <= count;
                            phase_q     <= PhaseInit;
                        end
                    end
                end
                StHigh: begin
                    if (phase_q == '0) begin
                        state_q <= StLow;
                        clk_dut <= 1'b0;
                        phase_q <= PhaseInit;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                StLow: begin
                    if (phase_q == '0) begin
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            if (AUTO_GET) begin
                                state_q <= StCap;
                            end else begin
                                state_q <= StIdle;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            state_q <= StHigh;
                            clk_dut <= 1'b1;
                            phase_q <= PhaseInit;
                        end
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                StCap: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/emu_step_transactor.sv
// Host byte-bus transactor: stimulus shadow/commit, output capture array and
// status readback, driving a generic DUT through a stepped clock.
module emu_step_transactor
    import emu_pkg::*;
#(
    parameter int unsigned NUM_STIM = 2,
    parameter int unsigned NUM_OUT  = 4,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned HALF_PER = 1,
    parameter bit          AUTO_GET = 1'b1
) (
    input  logic                  clk_emu,
    input  logic                  nrst_emu,
    input  logic [7:0]            Din_emu,
    output logic [7:0]            Dout_emu,
    input  logic [ADDR_W-1:0]     Addr_emu,
    input  logic                  load_emu,
    input  logic                  get_emu,
    input  logic                  step_emu,
    output logic                  busy_emu,
    output logic                  clk_dut,
    output logic [8*NUM_STIM-1:0] stim_dut,
    input  logic [8*NUM_OUT-1:0]  out_dut
);

    if (NUM_STIM < 1 || NUM_STIM >= (1 << ADDR_W)) begin : gen_bad_num_stim
        $error("NUM_STIM must be in 1..2**ADDR_W-1");
    end
    if (NUM_OUT < 1 || NUM_OUT >= (1 << ADDR_W)) begin : gen_bad_num_out
        $error("NUM_OUT must be in 1..2**ADDR_W-1");
    end
    if (HALF_PER < 1) begin : gen_bad_half_per
        $error("HALF_PER must be at least 1");
    end

    localparam logic [ADDR_W-1:0] StatusAddr = ADDR_W'(status_addr(ADDR_W));

    logic [7:0] stim_q [NUM_STIM];
    logic [7:0] vect_q [NUM_OUT];
    logic [7:0] rd_data;
    logic       done;
    logic       cap_pulse;
    logic       strobe;
    logic       load_act;
    logic       get_act;
    logic       step_act;

    // Only the highest-priority strobe may act, and none act during a burst.
    assign strobe   = load_emu | get_emu | step_emu;
    assign load_act = load_emu & ~busy_emu;
    assign get_act  = get_emu & ~load_emu & ~busy_emu;
    assign step_act = step_emu & ~load_emu & ~get_emu & ~busy_emu;

    emu_clk_stepper #(
        .HALF_PER(HALF_PER),
        .AUTO_GET(AUTO_GET)
    ) u_stepper (
        .clk_emu  (clk_emu),
        .nrst_emu (nrst_emu),
        .start    (step_act),
        .count    (Din_emu),
        .clr_done (load_act),
        .clk_dut  (clk_dut),
        .busy     (busy_emu),
        .done     (done),
        .cap_pulse(cap_pulse)
    );

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (Addr_emu == ADDR_W'(k)) begin
                rd_data = vect_q[k];
            end
        end
        if (Addr_emu == StatusAddr) begin
            rd_data[STATUS_BUSY_BIT] = busy_emu;
            rd_data[STATUS_DONE_BIT] = done;
        end
    end

    always_ff @(posedge clk_emu or negedge nrst_emu) begin
        if (!nrst_emu) begin
            for (int k = 0; k < NUM_STIM; k++) begin
                stim_q[k] <= 8'h00;
            end
        end else if (!strobe) begin
            for (int k = 0; k < NUM_STIM; k++) begin
                if (Addr_emu == ADDR_W'(k)) begin
                    stim_q[k] <= Din_emu;
                end
            end
        end
    end

    // Whole shadow moves in one edge so the DUT never sees a half-updated vector.
    always_ff @(posedge clk_emu or negedge nrst_emu) begin
        if (!nrst_emu) begin
            stim_dut <= '0;
        end else if (load_act) begin
            for (int k = 0; k < NUM_STIM; k++) begin
                stim_dut[8*k +: 8] <= stim_q[k];
            end
        end
    end

    always_ff @(posedge clk_emu or negedge nrst_emu) begin
        if (!nrst_emu) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                vect_q[k] <= 8'h00;
            end
        end else if (get_act || cap_pulse) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                vect_q[k] <= out_dut[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_emu or negedge nrst_emu) begin
        if (!nrst_emu) begin
            Dout_emu <= 8'h00;
        end else if (!strobe) begin
            Dout_emu <= rd_data;
        end
    end

endmodule

// File: doc/emu_step_transactor.md
Name: emu_step_transactor

Overview:
- Parametrised successor to the per-design co-emulation wrappers: a generic byte-addressed stimulus/capture transactor plus an on-chip DUT clock step engine.
- The host loads NUM_STIM stimulus bytes, commits them atomically to the DUT, and issues an N-cycle clock burst.
- Outputs are captured automatically at the end of the burst, or on demand.
- Sits between the host byte bus (Din_emu/Dout_emu/Addr_emu) and any DUT. Per-design wrappers reduce to bit-mapping stim_dut/out_dut.

Parameters:
NUM_STIM, 2, number of stimulus bytes (1..2**ADDR_W-1)
NUM_OUT, 4, number of capture bytes (1..2**ADDR_W-1)
ADDR_W, 3, host address width
HALF_PER, 1, clk_emu cycles per clk_dut half-period (>=1)
AUTO_GET, 1, 1 = capture out_dut automatically when a burst completes

Ports:
clk_emu  input  1  transactor clock, all logic on rising edge
nrst_emu  input  1  asynchronous active-low reset
Din_emu  input  8  host write data / step count
Dout_emu  output  8  host read data, registered
Addr_emu  input  ADDR_W  byte address
load_emu  input  1  commit stimulus shadow to stim_dut
get_emu  input  1  capture out_dut into output array
step_emu  input  1  start burst of Din_emu clk_dut cycles
busy_emu  output  1  burst in progress
clk_dut  output  1  generated DUT clock
stim_dut  output  8*NUM_STIM  committed stimulus, byte k at [8k+7:8k]
out_dut  input  8*NUM_OUT  DUT outputs, byte k at [8k+7:8k]

Behaviour:
- Reset (async, nrst_emu=0): stimIn shadow, stim_dut, vectOut, Dout_emu = 0; clk_dut=0; busy_emu=0; done=0; state IDLE.
- Strobe priority per cycle: load_emu > get_emu > step_emu > access. Only the highest asserted strobe acts.
- Access cycle (no strobe acts):
  - stimIn[Addr_emu] <= Din_emu when Addr_emu < NUM_STIM; otherwise the write is dropped.
  - Dout_emu <= vectOut[Addr_emu] when Addr_emu < NUM_OUT.
  - Dout_emu <= {busy_emu, done, 6'b0} when Addr_emu = 2**ADDR_W-1 (status address).
  - Dout_emu <= 8'h00 for any other address.
  - Read latency is 1 cycle.
- Dout_emu holds its value during any strobe cycle.
- load: stim_dut <= entire stimIn shadow in one edge (atomic); clears done. Ignored while busy_emu=1.
- get: entire vectOut <= out_dut in one edge. Ignored while busy_emu=1.
- step: latch N=Din_emu. Ignored while busy_emu=1. N=0 is a no-op apart from done: done<=1, no clock pulse, no capture.
- Step FSM: IDLE, HIGH, LOW, CAP.
  - IDLE--step(N>0)-->HIGH: clk_dut<=1, busy_emu<=1, done<=0, remaining<=N, phase counter<=HALF_PER-1.
  - HIGH: hold clk_dut=1 for HALF_PER cycles, then -->LOW with clk_dut<=0.
  - LOW: hold clk_dut=0 for HALF_PER cycles, then decrement remaining.
    - remaining>0 -->HIGH.
    - else AUTO_GET=1 -->CAP; AUTO_GET=0 -->IDLE with busy_emu<=0, done<=1.
  - CAP: vectOut <= out_dut; busy_emu<=0; done<=1; -->IDLE. This gives one full clk_emu cycle of settling after the final falling edge.
- Each clk_dut period is exactly 2*HALF_PER clk_emu cycles. There are exactly N rising edges per burst.
- Stimulus shadow writes and reads of vectOut/status remain legal during a burst. stim_dut does not change mid-burst, because load is ignored while busy.
- Counter widths: remaining 8 bits; phase counter clog2(HALF_PER) bits (minimum 1).
- Reset mid-burst: immediate abort. clk_dut=0, busy=0, no capture.
- Elaboration error if NUM_STIM or NUM_OUT >= 2**ADDR_W.

Decomposition:
- Package emu_pkg: state enum (IDLE/HIGH/LOW/CAP), STATUS byte bit positions (BUSY=7, DONE=6), localparam STATUS_ADDR = 2**ADDR_W-1.
- One sub-module, emu_clk_stepper: FSM, phase/remaining counters, clk_dut, busy, done, and a cap_pulse output.
- The top holds the arrays, strobe priority and read mux.

Test Plan:
- Reset then read status (Addr=7) -> Dout_emu=8'h00; stim_dut=0; clk_dut=0.
- Write 8'hA5 @0 and 8'h3C @1, then load -> stim_dut=16'h3CA5 on the next edge. Write 8'hFF @5 -> stim_dut unchanged.
- HALF_PER=2, AUTO_GET=1, out_dut=32'h1234_5678, step with Din=3:
  - exactly 3 clk_dut rising edges, each high 2 and low 2 clk_emu cycles;
  - busy high for 13 cycles;
  - then reads of @0..3 give 78,56,34,12 and status reads 8'h40.
- step Din=0 -> no clk_dut edge, busy stays 0, status 8'h40. load then step Din=0 during a burst -> ignored, the burst completes with its original count.
- load, get and step asserted together -> only load acts: stim_dut updates, vectOut unchanged, no burst.
- nrst_emu pulled low during the HIGH phase of a burst with N=5 -> clk_dut=0 and busy=0 asynchronously; vectOut=0; no capture.
